axis_packet_arbiter: RTL and testbench
======================================

Name: axis_packet_arbiter

Overview:
- Shares one AXI-Stream master output among NUM_INPUTS slave inputs, granting whole packets.
- Arbitration is round-robin.
- Once an input is granted, it is locked onto the output until the beat carrying tlast completes its handshake.
- Sits ahead of shared stream resources (width converters, MACs, FIFOs) wherever several packet sources feed one sink.

Parameters:
- AXIS_BYTES, 1, tdata width in bytes for all inputs and the output; tkeep is AXIS_BYTES bits.
- NUM_INPUTS, 2, number of requesting input streams; legal range 2..16.

Ports:
- clk  input  1  clock
- sresetn  input  1  synchronous active-low reset
- axis_i_tready  output  NUM_INPUTS  per-input ready; bit n belongs to input n
- axis_i_tvalid  input  NUM_INPUTS  per-input valid
- axis_i_tlast  input  NUM_INPUTS  per-input last
- axis_i_tkeep  input  NUM_INPUTS*AXIS_BYTES  concatenated keep; input n occupies slice [n*AXIS_BYTES +: AXIS_BYTES]
- axis_i_tdata  input  NUM_INPUTS*AXIS_BYTES*8  concatenated data; input n occupies slice [n*AXIS_BYTES*8 +: AXIS_BYTES*8]
- axis_o_tready  input  1  output ready
- axis_o_tvalid  output  1  output valid
- axis_o_tlast  output  1  output last
- axis_o_tkeep  output  AXIS_BYTES  output keep
- axis_o_tdata  output  AXIS_BYTES*8  output data
- grant_valid  output  1  high while a packet is locked
- grant_idx  output  clog2(NUM_INPUTS)  index of the locked input; holds the last granted index when grant_valid=0

Behaviour:
- One clock domain. All state updates on posedge clk. sresetn sampled synchronously.
- State machine with two states.
  - IDLE: no grant; all axis_i_tready=0; axis_o_tvalid=0.
  - LOCKED: input grant_idx is connected to the output.
- Reset: state=IDLE, grant_valid=0, grant_idx=NUM_INPUTS-1. This gives input 0 first priority after reset.
- IDLE -> LOCKED:
  - Trigger: any axis_i_tvalid bit is high.
  - Winner: the first set bit searching upward from (grant_idx+1) mod NUM_INPUTS, wrapping round.
  - The winner is registered into grant_idx and grant_valid goes to 1 next cycle.
  - Arbitration latency: 1 cycle from tvalid seen in IDLE to axis_o_tvalid.
- LOCKED datapath is combinational, with no extra latency:
  - axis_o_tvalid/tlast/tkeep/tdata = the input[grant_idx] fields.
  - axis_i_tready[grant_idx] = axis_o_tready; every other axis_i_tready bit = 0.
- LOCKED -> IDLE: when axis_o_tvalid && axis_o_tready && axis_o_tlast. The beat carrying tlast transfers in that cycle.
  - Exactly one bubble cycle follows every packet.
  - The next winner searches from (grant_idx+1), so the input just served gets lowest priority.
- Lock rules:
  - Requests from other inputs during LOCKED are ignored until the lock releases; they are not lost, because those inputs still hold tvalid.
  - The granted input may drop tvalid mid-packet. The lock is held and axis_o_tvalid follows it low.
- Backpressure: axis_o_tready low holds the lock. No beats are dropped or duplicated.
- Single-beat packets (tlast on first beat): LOCKED for exactly one handshake cycle, then IDLE.
- Reset mid-packet: immediately IDLE, grant_valid=0, all tready=0 from the next cycle. The remainder of the interrupted packet is re-arbitrated as a new packet. Integrity across reset is the upstream's responsibility.
- Outputs in IDLE: axis_o_tlast/tkeep/tdata reflect input[grant_idx] but are don't-care because tvalid=0. axis_o_tvalid must be 0.
- Simultaneous events: a handshake with tlast in the same cycle as new requests always transitions to IDLE first. There is no same-cycle regrant.

Test Plan:
- Reset, then input 2 only sends a 3-beat packet (NUM_INPUTS=4, AXIS_BYTES=2, data 0x1111,0x2222,0x3333) -> grant_idx=2 one cycle after tvalid; output reproduces the three words in order with tlast on 0x3333; grant_valid drops the cycle after.
- All 4 inputs continuously offer 1-beat packets -> output order is inputs 0,1,2,3,0,1...; each packet is followed by one idle cycle.
- Input 0 sends a 4-beat packet; input 1 raises tvalid on beat 2 -> axis_i_tready[1] stays 0 until input 0's tlast handshake; input 1 is granted next, with no interleaved beats.
- axis_o_tready toggles 1,0,0,1 during a 4-beat packet -> each beat appears exactly once, and the source holds data while stalled.
- Granted input drops tvalid for 2 cycles mid-packet while another input requests -> the lock is held, and the other input is not granted until tlast.
- sresetn pulsed low for 1 cycle during beat 2 of a packet from input 3 -> next cycle grant_valid=0 and all tready=0; after release, input 0 has priority if requesting.

Source files
------------

// File: rtl/axis_packet_arbiter.sv
`default_nettype none
// ============================================================================
// axis_packet_arbiter : round-robin AXI-Stream arbiter granting whole packets
// Revision 1.0
// ============================================================================
module axis_packet_arbiter #(
  parameter int AXIS_BYTES = 1,
  parameter int NUM_INPUTS = 2
) (
  input  logic                             clk,
  input  logic                             sresetn,
  output logic [NUM_INPUTS-1:0]            axis_i_tready,
  input  logic [NUM_INPUTS-1:0]            axis_i_tvalid,
  input  logic [NUM_INPUTS-1:0]            axis_i_tlast,
  input  logic [NUM_INPUTS*AXIS_BYTES-1:0] axis_i_tkeep,
  input  logic [NUM_INPUTS*AXIS_BYTES*8-1:0] axis_i_tdata,
  input  logic                             axis_o_tready,
  output logic                             axis_o_tvalid,
  output logic                             axis_o_tlast,
  output logic [AXIS_BYTES-1:0]            axis_o_tkeep,
  output logic [AXIS_BYTES*8-1:0]          axis_o_tdata,
  output logic                             grant_valid,
  output logic [$clog2(NUM_INPUTS)-1:0]    grant_idx
);

  localparam int DATA_W = AXIS_BYTES * 8;
  localparam int IDX_W  = $clog2(NUM_INPUTS);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [IDX_W-1:0]   grant_idx_nxt;
  logic [IDX_W-1:0]   winner;
  logic [IDX_W-1:0]   winner_hi;
  logic [IDX_W-1:0]   winner_lo;
  logic               found_hi;
  logic               sel_tvalid;
  logic               sel_tlast;
  logic [AXIS_BYTES-1:0] sel_tkeep;
  logic [DATA_W-1:0]  sel_tdata;

  // Round-robin search: the lowest requester above grant_idx wins, otherwise
  // wrap round to the lowest requester at or below it.
  always_comb begin
    winner_hi = '0;
    winner_lo = '0;
    found_hi  = 1'b0;
    for (int i = NUM_INPUTS - 1; i >= 0; i--) begin
      if (axis_i_tvalid[i]) begin
        if (IDX_W'(i) > grant_idx) begin
          found_hi  = 1'b1;
          winner_hi = IDX_W'(i);
        end else begin
          winner_lo = IDX_W'(i);
        end
      end
    end
  end

  assign winner = found_hi ? winner_hi : winner_lo;

  // Selected-input mux; also drives the output fields while idle.
  always_comb begin
    sel_tvalid = 1'b0;
    sel_tlast  = 1'b0;
    sel_tkeep  = '0;
    sel_tdata  = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      if (grant_idx == IDX_W'(i)) begin
        sel_tvalid = axis_i_tvalid[i];
        sel_tlast  = axis_i_tlast[i];
        sel_tkeep  = axis_i_tkeep[i*AXIS_BYTES +: AXIS_BYTES];
        sel_tdata  = axis_i_tdata[i*DATA_W +: DATA_W];
      end
    end
  end

  assign grant_valid   = (state == LOCKED);
  assign axis_o_tvalid = grant_valid && sel_tvalid;
  assign axis_o_tlast  = sel_tlast;
  assign axis_o_tkeep  = sel_tkeep;
  assign axis_o_tdata  = sel_tdata;

  always_comb begin
    axis_i_tready = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      if (grant_valid && (grant_idx == IDX_W'(i))) begin
        axis_i_tready[i] = axis_o_tready;
      end
    end
  end

  // Release only on the tlast handshake; a new grant always waits one cycle.
  always_comb begin
    state_nxt     = state;
    grant_idx_nxt = grant_idx;
    case (state)
      IDLE: begin
        if (|axis_i_tvalid) begin
          state_nxt     = LOCKED;
          grant_idx_nxt = winner;
        end
      end
      LOCKED: begin
        if (axis_o_tvalid && axis_o_tready && axis_o_tlast) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Reset index of NUM_INPUTS-1 makes input 0 the first in line.
  always_ff @(posedge clk) begin
    if (!sresetn) begin
      state     <= IDLE;
      grant_idx <= IDX_W'(NUM_INPUTS - 1);
    end else begin
      state     <= state_nxt;
      grant_idx <= grant_idx_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_axis_packet_arbiter.sv
`default_nettype none
// ============================================================================
// tb_axis_packet_arbiter : directed table-driven bench, 4 inputs x 2 bytes
// ============================================================================
module tb_axis_packet_arbiter;

  localparam int NI = 4;
  localparam int NB = 2;

  logic          clk = 1'b0;
  logic          sresetn;
  logic [NI-1:0] axis_i_tready;
  logic [NI-1:0] axis_i_tvalid;
  logic [NI-1:0] axis_i_tlast;
  logic [NI*NB-1:0]   axis_i_tkeep;
  logic [NI*NB*8-1:0] axis_i_tdata;
  logic          axis_o_tready;
  logic          axis_o_tvalid;
  logic          axis_o_tlast;
  logic [NB-1:0]   axis_o_tkeep;
  logic [NB*8-1:0] axis_o_tdata;
  logic          grant_valid;
  logic [1:0]    grant_idx;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  axis_packet_arbiter #(.AXIS_BYTES(NB), .NUM_INPUTS(NI)) dut (
    .clk(clk), .sresetn(sresetn),
    .axis_i_tready(axis_i_tready), .axis_i_tvalid(axis_i_tvalid),
    .axis_i_tlast(axis_i_tlast), .axis_i_tkeep(axis_i_tkeep),
    .axis_i_tdata(axis_i_tdata), .axis_o_tready(axis_o_tready),
    .axis_o_tvalid(axis_o_tvalid), .axis_o_tlast(axis_o_tlast),
    .axis_o_tkeep(axis_o_tkeep), .axis_o_tdata(axis_o_tdata),
    .grant_valid(grant_valid), .grant_idx(grant_idx)
  );

  typedef struct {
    logic        rstn;
    logic [3:0]  vld;
    logic [3:0]  lst;
    logic [63:0] dat;
    logic        ordy;
    logic        e_ovld;
    logic        e_olast;
    logic [15:0] e_odata;
    logic [3:0]  e_irdy;
    logic        e_gv;
    logic [1:0]  e_gi;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic rstn, input logic [3:0] vld, input logic [3:0] lst,
                              input logic [15:0] d0, input logic [15:0] d1,
                              input logic [15:0] d2, input logic [15:0] d3,
                              input logic ordy, input logic eov, input logic eol,
                              input logic [15:0] eod, input logic [3:0] eir,
                              input logic egv, input logic [1:0] egi);
    vec_t v;
    v.rstn = rstn; v.vld = vld; v.lst = lst; v.dat = {d3, d2, d1, d0}; v.ordy = ordy;
    v.e_ovld = eov; v.e_olast = eol; v.e_odata = eod; v.e_irdy = eir;
    v.e_gv = egv; v.e_gi = egi;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rstn, input logic [3:0] vld, input logic [3:0] lst,
                       input logic [63:0] dat, input logic ordy);
    sresetn       = rstn;
    axis_i_tvalid = vld;
    axis_i_tlast  = lst;
    axis_i_tdata  = dat;
    axis_o_tready = ordy;
  endtask

  initial begin
    logic [3:0] pat;
    int beat;
    int got;
    int cyc;

    axis_i_tkeep = '1;
    drive(1'b0, 4'b0, 4'b0, 64'h0, 1'b1);
    repeat (2) @(negedge clk);

    // Input 2 alone: 3-beat packet
    tbl.push_back(mk(1, 4'b0000, 4'b0000, 0, 0, 0, 0, 1, 0, 0, 0, 4'b0000, 0, 3));
    tbl.push_back(mk(1, 4'b0100, 4'b0000, 0, 0, 16'h1111, 0, 1, 0, 0, 0, 4'b0000, 0, 3));
    tbl.push_back(mk(1, 4'b0100, 4'b0000, 0, 0, 16'h1111, 0, 1, 1, 0, 16'h1111, 4'b0100, 1, 2));
    tbl.push_back(mk(1, 4'b0100, 4'b0000, 0, 0, 16'h2222, 0, 1, 1, 0, 16'h2222, 4'b0100, 1, 2));
    tbl.push_back(mk(1, 4'b0100, 4'b0100, 0, 0, 16'h3333, 0, 1, 1, 1, 16'h3333, 4'b0100, 1, 2));
    tbl.push_back(mk(1, 4'b0000, 4'b0000, 0, 0, 0, 0, 1, 0, 0, 0, 4'b0000, 0, 2));
    // Reset, then all four offer single-beat packets continuously
    tbl.push_back(mk(0, 4'b0000, 4'b0000, 0, 0, 0, 0, 1, 0, 0, 0, 4'b0000, 0, 2));
    tbl.push_back(mk(1, 4'b1111, 4'b1111, 16'hA000, 16'hA001, 16'hA002, 16'hA003, 1, 0, 0, 0, 4'b0000, 0, 3));
    tbl.push_back(mk(1, 4'b1111, 4'b1111, 16'hA000, 16'hA001, 16'hA002, 16'hA003, 1, 1, 1, 16'hA000, 4'b0001, 1, 0));
    tbl.push_back(mk(1, 4'b1111, 4'b1111, 16'hA000, 16'hA001, 16'hA002, 16'hA003, 1, 0, 0, 0, 4'b0000, 0, 0));
    tbl.push_back(mk(1, 4'b1111, 4'b1111, 16'hA000, 16'hA001, 16'hA002, 16'hA003, 1, 1, 1, 16'hA001, 4'b0010, 1, 1));
    tbl.push_back(mk(1, 4'b1111, 4'b1111, 16'hA000, 16'hA001, 16'hA002, 16'hA003, 1, 0, 0, 0, 4'b0000, 0, 1));
    tbl.push_back(mk(1, 4'b1111, 4'b1111, 16'hA000, 16'hA001, 16'hA002, 16'hA003, 1, 1, 1, 16'hA002, 4'b0100, 1, 2));
    tbl.push_back(mk(1, 4'b1111, 4'b1111, 16'hA000, 16'hA001, 16'hA002, 16'hA003, 1, 0, 0, 0, 4'b0000, 0, 2));
    tbl.push_back(mk(1, 4'b1111, 4'b1111, 16'hA000, 16'hA001, 16'hA002, 16'hA003, 1, 1, 1, 16'hA003, 4'b1000, 1, 3));
    tbl.push_back(mk(1, 4'b1111, 4'b1111, 16'hA000, 16'hA001, 16'hA002, 16'hA003, 1, 0, 0, 0, 4'b0000, 0, 3));
    tbl.push_back(mk(1, 4'b1111, 4'b1111, 16'hA000, 16'hA001, 16'hA002, 16'hA003, 1, 1, 1, 16'hA000, 4'b0001, 1, 0));
    tbl.push_back(mk(1, 4'b0000, 4'b0000, 0, 0, 0, 0, 1, 0, 0, 0, 4'b0000, 0, 0));
    // Input 0 4-beat packet; input 1 requests mid-packet and must wait
    tbl.push_back(mk(1, 4'b0001, 4'b0000, 16'hB000, 0, 0, 0, 1, 0, 0, 0, 4'b0000, 0, 0));
    tbl.push_back(mk(1, 4'b0001, 4'b0000, 16'hB000, 0, 0, 0, 1, 1, 0, 16'hB000, 4'b0001, 1, 0));
    tbl.push_back(mk(1, 4'b0011, 4'b0010, 16'hB001, 16'hC000, 0, 0, 1, 1, 0, 16'hB001, 4'b0001, 1, 0));
    tbl.push_back(mk(1, 4'b0011, 4'b0010, 16'hB002, 16'hC000, 0, 0, 1, 1, 0, 16'hB002, 4'b0001, 1, 0));
    tbl.push_back(mk(1, 4'b0011, 4'b0011, 16'hB003, 16'hC000, 0, 0, 1, 1, 1, 16'hB003, 4'b0001, 1, 0));
    tbl.push_back(mk(1, 4'b0010, 4'b0010, 0, 16'hC000, 0, 0, 1, 0, 0, 0, 4'b0000, 0, 0));
    tbl.push_back(mk(1, 4'b0010, 4'b0010, 0, 16'hC000, 0, 0, 1, 1, 1, 16'hC000, 4'b0010, 1, 1));
    tbl.push_back(mk(1, 4'b0000, 4'b0000, 0, 0, 0, 0, 1, 0, 0, 0, 4'b0000, 0, 1));
    // Input 2 drops tvalid for 2 cycles while input 3 waits
    tbl.push_back(mk(1, 4'b0100, 4'b0000, 0, 0, 16'hD000, 0, 1, 0, 0, 0, 4'b0000, 0, 1));
    tbl.push_back(mk(1, 4'b1100, 4'b1000, 0, 0, 16'hD000, 16'hE000, 1, 1, 0, 16'hD000, 4'b0100, 1, 2));
    tbl.push_back(mk(1, 4'b1000, 4'b1000, 0, 0, 16'hD001, 16'hE000, 1, 0, 0, 0, 4'b0100, 1, 2));
    tbl.push_back(mk(1, 4'b1000, 4'b1000, 0, 0, 16'hD001, 16'hE000, 1, 0, 0, 0, 4'b0100, 1, 2));
    tbl.push_back(mk(1, 4'b1100, 4'b1100, 0, 0, 16'hD001, 16'hE000, 1, 1, 1, 16'hD001, 4'b0100, 1, 2));
    tbl.push_back(mk(1, 4'b1000, 4'b1000, 0, 0, 0, 16'hE000, 1, 0, 0, 0, 4'b0000, 0, 2));
    tbl.push_back(mk(1, 4'b1000, 4'b1000, 0, 0, 0, 16'hE000, 1, 1, 1, 16'hE000, 4'b1000, 1, 3));
    tbl.push_back(mk(1, 4'b0000, 4'b0000, 0, 0, 0, 0, 1, 0, 0, 0, 4'b0000, 0, 3));

    foreach (tbl[i]) begin
      @(negedge clk);
      drive(tbl[i].rstn, tbl[i].vld, tbl[i].lst, tbl[i].dat, tbl[i].ordy);
      #1;
      chk($sformatf("row%0d_ovld", i), 32'(axis_o_tvalid), 32'(tbl[i].e_ovld));
      chk($sformatf("row%0d_irdy", i), 32'(axis_i_tready), 32'(tbl[i].e_irdy));
      chk($sformatf("row%0d_gv", i), 32'(grant_valid), 32'(tbl[i].e_gv));
      chk($sformatf("row%0d_gi", i), 32'(grant_idx), 32'(tbl[i].e_gi));
      if (tbl[i].e_ovld) begin
        chk($sformatf("row%0d_odata", i), 32'(axis_o_tdata), 32'(tbl[i].e_odata));
        chk($sformatf("row%0d_olast", i), 32'(axis_o_tlast), 32'(tbl[i].e_olast));
        chk($sformatf("row%0d_okeep", i), 32'(axis_o_tkeep), 32'h3);
      end
    end

    // Backpressure: output ready cycles 1,0,0,1 under a 4-beat packet from input 1
    pat  = 4'b1001;
    beat = 0;
    got  = 0;
    cyc  = 0;
    while (got < 4 && cyc < 40) begin
      @(negedge clk);
      drive(1'b1, 4'b0010, (beat == 3) ? 4'b0010 : 4'b0000,
            {16'h0, 16'h0, 16'(16'hF000 + beat), 16'h0}, pat[cyc % 4]);
      #1;
      if (grant_valid)
        chk($sformatf("bp_irdy_c%0d", cyc), 32'(axis_i_tready), {28'h0, 2'b00, axis_o_tready, 1'b0});
      if (axis_o_tvalid && axis_o_tready) begin
        chk($sformatf("bp_data_b%0d", got), 32'(axis_o_tdata), 32'(16'hF000 + got));
        chk($sformatf("bp_last_b%0d", got), 32'(axis_o_tlast), 32'(got == 3));
        got++;
      end
      if (axis_i_tready[1] && axis_i_tvalid[1]) beat++;
      cyc++;
    end
    chk("bp_beats", 32'(got), 32'd4);
    @(negedge clk);
    drive(1'b1, 4'b0000, 4'b0000, 64'h0, 1'b1);
    #1;
    chk("bp_after_gv", 32'(grant_valid), 32'd0);
    chk("bp_after_gi", 32'(grant_idx), 32'd1);

    // Reset pulse during beat 2 of an input-3 packet
    @(negedge clk);
    drive(1'b1, 4'b1000, 4'b0000, {16'h9000, 48'h0}, 1'b1);
    @(negedge clk);
    #1;
    chk("rst_b1_gi", 32'(grant_idx), 32'd3);
    chk("rst_b1_data", 32'(axis_o_tdata), 32'h9000);
    @(negedge clk);
    drive(1'b0, 4'b1000, 4'b0000, {16'h9001, 48'h0}, 1'b1);
    @(negedge clk);
    drive(1'b1, 4'b1001, 4'b0001, {16'h9001, 32'h0, 16'h8000}, 1'b1);
    #1;
    chk("rst_gv", 32'(grant_valid), 32'd0);
    chk("rst_irdy", 32'(axis_i_tready), 32'd0);
    chk("rst_ovld", 32'(axis_o_tvalid), 32'd0);
    chk("rst_gi", 32'(grant_idx), 32'd3);
    @(negedge clk);
    #1;
    chk("post_rst_gv", 32'(grant_valid), 32'd1);
    chk("post_rst_gi", 32'(grant_idx), 32'd0);
    chk("post_rst_irdy", 32'(axis_i_tready), 32'b0001);
    chk("post_rst_data", 32'(axis_o_tdata), 32'h8000);
    chk("post_rst_last", 32'(axis_o_tlast), 32'd1);
    @(negedge clk);
    drive(1'b1, 4'b0000, 4'b0000, 64'h0, 1'b1);
    #1;
    chk("end_gv", 32'(grant_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
